// File: rtl/traffic_light_pkg.sv
// Shared state encoding and lamp patterns for the road/farm/pedestrian light controller.
// Lamp vectors are packed {G,Y,R}.
package traffic_light_pkg;

    localparam int PHASE_W = 4;

    typedef enum logic [PHASE_W-1:0] {
        S_R1G   = 4'd0,
        S_R1Y   = 4'd1,
        S_AR1   = 4'd2,
        S_R2G   = 4'd3,
        S_R2Y   = 4'd4,
        S_AR2   = 4'd5,
        S_FG    = 4'd6,
        S_FY    = 4'd7,
        S_AR3   = 4'd8,
        S_FLASH = 4'd9
    } state_t;

    localparam logic [2:0] LAMP_G   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_R   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/traffic_light_param_if.sv
// Sensor/request inputs and lamp/debug outputs of the light controller.
// master drives requests and watches lamps; slave is the controller side.
interface traffic_light_param_if;
    import traffic_light_pkg::*;

    logic               c;
    logic               ped_req;
    logic               night;
    logic [2:0]         r1_light;
    logic [2:0]         r2_light;
    logic [2:0]         f_light;
    logic               walk;
    logic [PHASE_W-1:0] phase;

    modport master (
        output c, ped_req, night,
        input  r1_light, r2_light, f_light, walk, phase
    );

    modport slave (
        input  c, ped_req, night,
        output r1_light, r2_light, f_light, walk, phase
    );

endinterface

// File: rtl/phase_timer.sv
// Phase cycle counter: resets/reloads to 1, otherwise counts up; compares are combinational.
// Latency: reload visible the cycle after it is requested; no backpressure.
module phase_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reload,
    input  logic [CNT_W-1:0] term_val,
    input  logic [CNT_W-1:0] thr_val,
    output logic             at_term,
    output logic             at_thr
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= CNT_W'(1);
        end else if (reload) begin
            cnt <= CNT_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign at_term = (cnt == term_val);
    assign at_thr  = (cnt >= thr_val);

endmodule

// File: rtl/traffic_light_param.sv
// Two-road plus farm-road light controller with pedestrian shortening and night flash.
// Latency: Moore outputs change one cycle after the deciding edge; no backpressure.
module traffic_light_param
    import traffic_light_pkg::*;
#(
    parameter int CNT_W      = 6,
    parameter int T_MAIN_G   = 30,
    parameter int T_MIN_G    = 10,
    parameter int T_FARM_G   = 15,
    parameter int T_FARM_MIN = 5,
    parameter int T_Y        = 5,
    parameter int T_AR       = 2,
    parameter int T_BLINK    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    traffic_light_param_if.slave   io
);

    localparam int T_MAX = (1 << CNT_W) - 1;

    if (T_MAIN_G < 1 || T_MAIN_G > T_MAX || T_MIN_G < 1 || T_MIN_G > T_MAX ||
        T_FARM_G < 1 || T_FARM_G > T_MAX || T_FARM_MIN < 1 || T_FARM_MIN > T_MAX ||
        T_Y < 1 || T_Y > T_MAX || T_AR < 1 || T_AR > T_MAX ||
        T_BLINK < 1 || T_BLINK > T_MAX ||
        T_MIN_G > T_MAIN_G || T_FARM_MIN > T_FARM_G) begin : g_bad_timing
        $fatal(1, "traffic_light_param: illegal timing parameters");
    end

    state_t           state, state_nxt;
    logic             ped_pend, blink;
    logic             at_term, at_thr, reload;
    logic [CNT_W-1:0] term_val, thr_val;

    always_comb begin
        term_val = CNT_W'(T_AR);
        thr_val  = CNT_W'(T_MIN_G);
        case (state)
            S_R1G, S_R2G:      term_val = CNT_W'(T_MAIN_G);
            S_R1Y, S_R2Y, S_FY: term_val = CNT_W'(T_Y);
            S_FG: begin
                term_val = CNT_W'(T_FARM_G);
                thr_val  = CNT_W'(T_FARM_MIN);
            end
            S_FLASH:           term_val = CNT_W'(T_BLINK);
            default: ;
        endcase
    end

    // c and night only matter on the terminal cycle of the phase that consults them.
    always_comb begin
        state_nxt = state;
        case (state)
            S_R1G:   if (at_term || (ped_pend && at_thr)) state_nxt = S_R1Y;
            S_R1Y:   if (at_term) state_nxt = S_AR1;
            S_AR1:   if (at_term) state_nxt = io.night ? S_FLASH : (io.c ? S_FG : S_R2G);
            S_R2G:   if (at_term) state_nxt = S_R2Y;
            S_R2Y:   if (at_term) state_nxt = S_AR2;
            S_AR2:   if (at_term) state_nxt = io.night ? S_FLASH : (io.c ? S_FG : S_R1G);
            S_FG:    if (at_term || (!io.c && at_thr)) state_nxt = S_FY;
            S_FY:    if (at_term) state_nxt = S_AR3;
            S_AR3:   if (at_term) state_nxt = io.night ? S_FLASH : S_R1G;
            S_FLASH: if (at_term && !io.night) state_nxt = S_AR3;
            default: state_nxt = S_R1G;
        endcase
    end

    // FLASH restarts its count every half-period without leaving the state.
    assign reload = (state_nxt != state) || (state == S_FLASH && at_term);

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .reload   (reload),
        .term_val (term_val),
        .thr_val  (thr_val),
        .at_term  (at_term),
        .at_thr   (at_thr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_R1G;
            ped_pend <= 1'b0;
            blink    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_R2G || state_nxt == S_R2G) begin
                ped_pend <= 1'b0;
            end else if (io.ped_req) begin
                ped_pend <= 1'b1;
            end
            if (state == S_FLASH && at_term) begin
                blink <= ~blink;
            end
        end
    end

    always_comb begin
        io.r1_light = LAMP_R;
        io.r2_light = LAMP_R;
        io.f_light  = LAMP_R;
        case (state)
            S_R1G:   io.r1_light = LAMP_G;
            S_R1Y:   io.r1_light = LAMP_Y;
            S_R2G:   io.r2_light = LAMP_G;
            S_R2Y:   io.r2_light = LAMP_Y;
            S_FG:    io.f_light  = LAMP_G;
            S_FY:    io.f_light  = LAMP_Y;
            S_FLASH: begin
                io.r1_light = {1'b0, blink, 1'b0};
                io.r2_light = {1'b0, blink, 1'b0};
                io.f_light  = {2'b00, blink};
            end
            default: ;
        endcase
    end

    assign io.walk  = (state == S_R2G);
    assign io.phase = state;

endmodule

// File: doc/traffic_light_param.md
TRAFFIC_LIGHT_PARAM -- requirements
Module: traffic_light_param

Interface
REQ-001 Parameter CNT_W, default 6: phase counter width.
REQ-002 Parameter T_MAIN_G, default 30: road1/road2 full green length, cycles.
REQ-003 Parameter T_MIN_G, default 10: road1 minimum green when a pedestrian request is pending.
REQ-004 Parameter T_FARM_G, default 15: farm-road maximum green.
REQ-005 Parameter T_FARM_MIN, default 5: farm-road minimum green.
REQ-006 Parameter T_Y, default 5: yellow length, all roads.
REQ-007 Parameter T_AR, default 2: all-red clearance length.
REQ-008 Parameter T_BLINK, default 4: flash half-period.
REQ-009 clk  in  1  single clock, rising edge.
REQ-010 rst_n  in  1  reset, synchronous and active-low.
REQ-011 c  in  1  farm-road vehicle sensor, level.
REQ-012 ped_req  in  1  pedestrian button for crossing road 1, single-cycle or level.
REQ-013 night  in  1  flash-mode request, level.
REQ-014 r1_light, r2_light, f_light  out  3 each  {G,Y,R} lamp drives.
REQ-015 walk  out  1  pedestrian walk lamp.
REQ-016 phase  out  4  current state code, debug.

Function
REQ-017 States: R1G, R1Y, AR1, R2G, R2Y, AR2, FG, FY, AR3, FLASH; outputs Moore, decoded from state only.
REQ-018 Counter shall load 1 on every state change and increment otherwise; a state of length T lasts exactly T cycles.
REQ-019 R1G->R1Y at counter==T_MAIN_G, or at counter>=T_MIN_G when ped_pend=1.
REQ-020 R1Y->AR1 and R2Y->AR2 and FY->AR3 at counter==T_Y.
REQ-021 R2G->R2Y at counter==T_MAIN_G.
REQ-022 AR1 terminal (counter==T_AR): night -> FLASH; else c -> FG; else R2G.
REQ-023 AR2 terminal: night -> FLASH; else c -> FG; else R1G.
REQ-024 AR3 terminal: night -> FLASH; else R1G.
REQ-025 FG->FY at counter==T_FARM_G, or at counter>=T_FARM_MIN when c=0.
REQ-026 FLASH: counter reloads 1 at counter==T_BLINK and blink bit toggles; r1/r2 = {0,blink,0}, f = {0,0,blink}; walk=0.
REQ-027 FLASH exit: at counter==T_BLINK with night=0 -> AR3.
REQ-028 Non-FLASH states: each road drives exactly one lamp, green/yellow only in its own G/Y states, red otherwise; all-red states drive R on all roads.
REQ-029 walk=1 exactly while state==R2G.
REQ-030 ped_pend sets on ped_req; clears when next state is R2G or state is R2G; clear wins over simultaneous set.
REQ-031 c and night sampled only at the terminal cycles above; changes elsewhere have no effect.
REQ-032 Elaboration shall fail if any T_* parameter is 0 or exceeds 2^CNT_W-1, or T_MIN_G>T_MAIN_G, or T_FARM_MIN>T_FARM_G.

Reset
REQ-033 rst_n=0 at a clk edge: state=R1G, counter=1, ped_pend=0, blink=0; takes effect mid-phase, including in FLASH.
REQ-034 After reset release, R1G lasts T_MAIN_G cycles absent a pedestrian request.

Structure
REQ-035 Package traffic_light_pkg holds the state enum typedef, phase codes and {G,Y,R} lamp constants.
REQ-036 One sub-module, phase_timer: CNT_W counter with reload and terminal/threshold compares.

Verification
REQ-037 Defaults, c=0, no requests: R1G 30, R1Y 5, AR1 2, R2G 30, R2Y 5, AR2 2, repeat; period 74 cycles.
REQ-038 ped_req pulse at R1G counter 3 -> R1Y entered after counter 10; walk high for all 30 R2G cycles; ped_pend 0 afterwards.
REQ-039 c=1 through R1Y/AR1 -> FG; drop c at FG counter 3 -> FG holds to 5, then FY 5, AR3 2, R1G.
REQ-040 c held 1 -> FG lasts exactly 15 cycles.
REQ-041 night=1 during R2G -> FLASH after AR2; yellow toggles every 4 cycles; night=0 -> AR3 at next blink boundary, then R1G.
REQ-042 rst_n low one cycle during FG counter 7 -> next cycle R1G, counter 1, all outputs per REQ-028.
